// File: rtl/crb_pkg.sv
// Shared definitions for the CRB transfer engine: FSM states, header layout
// constants and the command/response length clamp.
package crb_pkg;

   localparam int unsigned LEN_W          = 32;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned MIN_SIZE       = 10;
   localparam int unsigned HDR_SIZE_OFS   = 2;
   localparam int unsigned HDR_SIZE_BYTES = 4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD_START,
      ST_CMD_XFER,
      ST_CMD_DRAIN,
      ST_EXEC,
      ST_HDR_RD,
      ST_RSP_NOTIFY,
      ST_RSP_WAIT,
      ST_RSP_XFER,
      ST_RSP_DONE
   } crbState_t;

   // Force a raw length into [MIN_SIZE, maxLen]
   function automatic logic [LEN_W-1:0] clampLen(input logic [LEN_W-1:0] raw,
                                                 input logic [LEN_W-1:0] maxLen);
      if (raw < LEN_W'(MIN_SIZE)) return LEN_W'(MIN_SIZE);
      if (raw > maxLen)           return maxLen;
      return raw;
   endfunction

endpackage

// File: rtl/crb_transfer_engine_if.sv
// FIFO-side and exec-side signal bundle of the CRB transfer engine.
// master = transfer engine, slave = FIFO / exec engine environment.
interface crb_transfer_engine_if
   import crb_pkg::*;
#(
   parameter int unsigned ADDR_W = 12
);

   logic                f_abort_i;
   logic                f_cmdSend_i;
   logic [LEN_W-1:0]    f_cmdSize_i;
   logic [BYTE_W-1:0]   f_cmdByte_i;
   logic [ADDR_W-1:0]   f_cmdAddr_o;
   logic                f_cmdDone_o;
   logic                f_execDone_o;
   logic [LEN_W-1:0]    f_rspSize_o;
   logic [BYTE_W-1:0]   f_rspByte_o;
   logic [ADDR_W-1:0]   f_rspAddr_o;
   logic                f_rspWren_n_o;
   logic                f_rspDone_o;
   logic                e_cmdReady_o;
   logic [LEN_W-1:0]    e_cmdSize_o;
   logic [ADDR_W-1:0]   e_addr_i;
   logic [BYTE_W-1:0]   e_wrData_i;
   logic                e_wren_n_i;
   logic [BYTE_W-1:0]   e_rdData_o;
   logic                e_execDone_i;
   logic                sizeErr_o;

   modport master (
      input  f_abort_i, f_cmdSend_i, f_cmdSize_i, f_cmdByte_i,
             e_addr_i, e_wrData_i, e_wren_n_i, e_execDone_i,
      output f_cmdAddr_o, f_cmdDone_o, f_execDone_o, f_rspSize_o,
             f_rspByte_o, f_rspAddr_o, f_rspWren_n_o, f_rspDone_o,
             e_cmdReady_o, e_cmdSize_o, e_rdData_o, sizeErr_o
   );

   modport slave (
      output f_abort_i, f_cmdSend_i, f_cmdSize_i, f_cmdByte_i,
             e_addr_i, e_wrData_i, e_wren_n_i, e_execDone_i,
      input  f_cmdAddr_o, f_cmdDone_o, f_execDone_o, f_rspSize_o,
             f_rspByte_o, f_rspAddr_o, f_rspWren_n_o, f_rspDone_o,
             e_cmdReady_o, e_cmdSize_o, e_rdData_o, sizeErr_o
   );

endinterface

// File: rtl/GENERIC_BUFFER.sv
// Single-port synchronous RAM with one-cycle registered read.
module GENERIC_BUFFER #(
   parameter int unsigned DEPTH  = 4096,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned DATA_W = 8
) (
   input  logic              clock_i,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wrData,
   output logic [DATA_W-1:0] rdData
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock_i) begin
      if (wrEn) mem[addr] <= wrData;
      rdData <= mem[addr];
   end

endmodule

// File: rtl/crb_transfer_engine.sv
// Moves a command from the FIFO into CRB RAM, hands it to the exec engine,
// then reads back the response length and streams the response into the FIFO.
module crb_transfer_engine
   import crb_pkg::*;
#(
   parameter int unsigned BUF_SIZE = 4096,
   parameter int unsigned RSP_DLY  = 2
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   crb_transfer_engine_if.master bus
);

   localparam int unsigned ADDR_W = $clog2(BUF_SIZE);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   crbState_t          state, stateNext;
   logic [CNT_W-1:0]   cnt, cntNext;
   logic [LEN_W-1:0]   cmdLen, cmdLenNext;
   logic [LEN_W-1:0]   rspLen, rspLenNext;
   logic [LEN_W-1:0]   rawSize, rawSizeNext;
   logic               sizeErr, sizeErrNext;
   logic [ADDR_W-1:0]  cmdAddr, cmdAddrNext;
   logic [ADDR_W-1:0]  rspAddr, rspAddrNext;
   logic               cmdDone, cmdDoneNext;
   logic               execDone, execDoneNext;
   logic               rspDone, rspDoneNext;
   logic               rspWrenN, rspWrenNNext;
   logic               cmdReady, cmdReadyNext;

   logic               ramWrEn;
   logic [ADDR_W-1:0]  ramAddr;
   logic [BYTE_W-1:0]  ramWrData;
   logic [BYTE_W-1:0]  ramRdData;

   GENERIC_BUFFER #(
      .DEPTH  (BUF_SIZE),
      .ADDR_W (ADDR_W),
      .DATA_W (BYTE_W)
   ) crbRam (
      .clock_i (clock_i),
      .wrEn    (ramWrEn),
      .addr    (ramAddr),
      .wrData  (ramWrData),
      .rdData  (ramRdData)
   );

   // Next state, RAM port mux and next values of all registered outputs
   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      cmdLenNext  = cmdLen;
      rspLenNext  = rspLen;
      rawSizeNext = rawSize;
      sizeErrNext = sizeErr;
      ramWrEn     = 1'b0;
      ramAddr     = '0;
      ramWrData   = bus.f_cmdByte_i;

      case (state)
         ST_IDLE: begin
            if (bus.f_cmdSend_i) begin
               stateNext   = ST_CMD_START;
               cmdLenNext  = clampLen(bus.f_cmdSize_i, LEN_W'(BUF_SIZE));
               sizeErrNext = (cmdLenNext != bus.f_cmdSize_i);
            end
         end
         ST_CMD_START: begin
            stateNext = ST_CMD_XFER;
            cntNext   = '0;
         end
         // FIFO data lags the address by one cycle, so byte k-1 lands while k is issued
         ST_CMD_XFER: begin
            ramWrEn = (cnt != '0);
            ramAddr = ADDR_W'(cnt - CNT_W'(1));
            cntNext = cnt + CNT_W'(1);
            if (LEN_W'(cnt) == cmdLen - LEN_W'(1)) stateNext = ST_CMD_DRAIN;
         end
         ST_CMD_DRAIN: begin
            ramWrEn   = 1'b1;
            ramAddr   = ADDR_W'(cnt - CNT_W'(1));
            stateNext = ST_EXEC;
         end
         ST_EXEC: begin
            ramWrEn   = ~bus.e_wren_n_i;
            ramAddr   = bus.e_addr_i;
            ramWrData = bus.e_wrData_i;
            if (bus.e_execDone_i) begin
               stateNext = ST_HDR_RD;
               cntNext   = '0;
            end
         end
         // Issue reads of the four size bytes; shift in big-endian as they return
         ST_HDR_RD: begin
            ramAddr = ADDR_W'(HDR_SIZE_OFS) + ADDR_W'(cnt);
            cntNext = cnt + CNT_W'(1);
            if (cnt != '0) rawSizeNext = {rawSize[LEN_W-BYTE_W-1:0], ramRdData};
            if (cnt == CNT_W'(HDR_SIZE_BYTES)) begin
               stateNext   = ST_RSP_NOTIFY;
               rspLenNext  = clampLen(rawSizeNext, LEN_W'(BUF_SIZE));
               sizeErrNext = sizeErr | (rspLenNext != rawSizeNext);
            end
         end
         ST_RSP_NOTIFY: begin
            stateNext = ST_RSP_WAIT;
            cntNext   = '0;
         end
         ST_RSP_WAIT: begin
            cntNext = cnt + CNT_W'(1);
            if (cnt == CNT_W'(RSP_DLY - 1)) begin
               stateNext = ST_RSP_XFER;
               cntNext   = '0;
            end
         end
         // Read one byte ahead so RAM data lines up with its write strobe
         ST_RSP_XFER: begin
            ramAddr = ADDR_W'(cnt + CNT_W'(1));
            cntNext = cnt + CNT_W'(1);
            if (LEN_W'(cnt) == rspLen - LEN_W'(1)) stateNext = ST_RSP_DONE;
         end
         ST_RSP_DONE: begin
            stateNext = ST_IDLE;
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase

      if (bus.f_abort_i) stateNext = ST_IDLE;

      if (stateNext == ST_IDLE) begin
         cmdLenNext  = '0;
         rspLenNext  = '0;
         sizeErrNext = 1'b0;
      end

      cmdReadyNext = (stateNext == ST_EXEC);
      cmdDoneNext  = (stateNext == ST_CMD_DRAIN);
      execDoneNext = (stateNext == ST_RSP_NOTIFY);
      rspDoneNext  = (stateNext == ST_RSP_DONE);
      rspWrenNNext = (stateNext != ST_RSP_XFER);
      cmdAddrNext  = (stateNext == ST_CMD_XFER) ? ADDR_W'(cntNext) : '0;
      rspAddrNext  = (stateNext == ST_RSP_XFER) ? ADDR_W'(cntNext) : '0;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cmdLen   <= '0;
         rspLen   <= '0;
         rawSize  <= '0;
         sizeErr  <= 1'b0;
         cmdAddr  <= '0;
         rspAddr  <= '0;
         cmdDone  <= 1'b0;
         execDone <= 1'b0;
         rspDone  <= 1'b0;
         rspWrenN <= 1'b1;
         cmdReady <= 1'b0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         cmdLen   <= cmdLenNext;
         rspLen   <= rspLenNext;
         rawSize  <= rawSizeNext;
         sizeErr  <= sizeErrNext;
         cmdAddr  <= cmdAddrNext;
         rspAddr  <= rspAddrNext;
         cmdDone  <= cmdDoneNext;
         execDone <= execDoneNext;
         rspDone  <= rspDoneNext;
         rspWrenN <= rspWrenNNext;
         cmdReady <= cmdReadyNext;
      end
   end

   assign bus.f_cmdAddr_o   = cmdAddr;
   assign bus.f_cmdDone_o   = cmdDone;
   assign bus.f_execDone_o  = execDone;
   assign bus.f_rspSize_o   = rspLen;
   assign bus.f_rspAddr_o   = rspAddr;
   assign bus.f_rspWren_n_o = rspWrenN;
   assign bus.f_rspDone_o   = rspDone;
   assign bus.f_rspByte_o   = rspWrenN ? '0 : ramRdData;
   assign bus.e_cmdReady_o  = cmdReady;
   assign bus.e_cmdSize_o   = cmdLen;
   assign bus.e_rdData_o    = ramRdData;
   assign bus.sizeErr_o     = sizeErr;

endmodule

// File: tb/tb_crb_transfer_engine.sv
// Randomized bench for crb_transfer_engine: FIFO/exec models plus a
// transaction-level reference of copy, header parse and response stream.
module tb_crb_transfer_engine;

   localparam int unsigned BUF_SIZE = 4096;
   localparam int unsigned ADDR_W   = 12;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   testsRun    = 0;
   int   testsFailed = 0;
   int   txnId       = 0;

   logic [7:0] fifoMem [BUF_SIZE];
   logic [7:0] rspMem  [BUF_SIZE];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   crb_transfer_engine_if #(.ADDR_W(ADDR_W)) bus ();

   crb_transfer_engine #(.BUF_SIZE(BUF_SIZE), .RSP_DLY(2)) dut (
      .clock_i (clock),
      .reset_i (reset),
      .bus     (bus)
   );

   // FIFO read port: one-cycle latency from address to data
   always @(posedge clock) bus.f_cmdByte_i <= fifoMem[bus.f_cmdAddr_o];

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL txn%0d %s: got 0x%0h expected 0x%0h", txnId, tag, got, exp);
      end
   endtask

   function automatic logic [31:0] expLen(input logic [31:0] raw);
      if (raw < 32'd10)   return 32'd10;
      if (raw > 32'd4096) return 32'd4096;
      return raw;
   endfunction

   task automatic checkIdle(input string tag);
      checkVal({tag, "Wren"},     32'(bus.f_rspWren_n_o), 32'd1);
      checkVal({tag, "Ready"},    32'(bus.e_cmdReady_o),  32'd0);
      checkVal({tag, "RspSize"},  bus.f_rspSize_o,        32'd0);
      checkVal({tag, "CmdSize"},  bus.e_cmdSize_o,        32'd0);
      checkVal({tag, "SizeErr"},  32'(bus.sizeErr_o),     32'd0);
      checkVal({tag, "Addrs"},    32'({bus.f_cmdAddr_o, bus.f_rspAddr_o}), 32'd0);
      checkVal({tag, "Pulses"},   32'({bus.f_cmdDone_o, bus.f_execDone_o, bus.f_rspDone_o}), 32'd0);
   endtask

   task automatic runTxn(input logic [31:0] cmdRaw, input logic [31:0] rspRaw,
                         input bit fixedCmd, input bit resetInRsp);
      logic [31:0] n, m;
      bit          cmdErr, rspErr;
      int          sendCyc, doneCyc, execCyc, notifyCyc, firstCyc, rspDoneCyc;
      int          t, bad, nWr, lastAddr;
      txnId++;
      n      = expLen(cmdRaw);
      m      = expLen(rspRaw);
      cmdErr = (n != cmdRaw);
      rspErr = (m != rspRaw);
      for (int i = 0; i < int'(n); i++) fifoMem[12'(i)] = 8'($urandom);
      if (fixedCmd) begin
         fifoMem[0] = 8'h80; fifoMem[1] = 8'h01; fifoMem[2] = 8'h00;
         fifoMem[3] = 8'h00; fifoMem[4] = 8'h00; fifoMem[5] = 8'h0C;
      end
      for (int j = 0; j < int'(m); j++) rspMem[12'(j)] = 8'($urandom);
      rspMem[2] = rspRaw[31:24]; rspMem[3] = rspRaw[23:16];
      rspMem[4] = rspRaw[15:8];  rspMem[5] = rspRaw[7:0];

      @(negedge clock);
      bus.f_cmdSize_i = cmdRaw;
      bus.f_cmdSend_i = 1'b1;
      sendCyc = cyc;
      @(negedge clock);
      bus.f_cmdSend_i = 1'b0;
      bus.f_cmdSize_i = $urandom;
      doneCyc = -1;
      t = 0;
      while (!bus.e_cmdReady_o && t < int'(n) + 20) begin
         if (bus.f_cmdDone_o) doneCyc = cyc;
         @(negedge clock);
         t++;
      end
      checkVal("cmdReady", 32'(bus.e_cmdReady_o), 32'd1);
      if (!bus.e_cmdReady_o) begin
         bus.f_abort_i = 1'b1;
         @(negedge clock);
         bus.f_abort_i = 1'b0;
         return;
      end
      checkVal("cmdDoneLat", 32'(doneCyc - sendCyc), n + 32'd2);
      checkVal("cmdSize",    bus.e_cmdSize_o, n);
      checkVal("sizeErrCmd", 32'(bus.sizeErr_o), 32'(cmdErr));

      // Exec reads the CRB back through its own port
      bad = 0;
      for (int i = 0; i <= int'(n); i++) begin
         if (i > 0 && bus.e_rdData_o !== fifoMem[12'(i - 1)]) bad++;
         if (i < int'(n)) bus.e_addr_i = 12'(i);
         @(negedge clock);
      end
      checkVal("cmdRamBadBytes", 32'(bad), 32'd0);

      // Exec writes the response; completion shares the last write cycle
      for (int j = 0; j < int'(m); j++) begin
         bus.e_addr_i     = 12'(j);
         bus.e_wrData_i   = rspMem[12'(j)];
         bus.e_wren_n_i   = 1'b0;
         bus.e_execDone_i = (j == int'(m) - 1);
         execCyc = cyc;
         @(negedge clock);
      end
      bus.e_wren_n_i   = 1'b1;
      bus.e_execDone_i = 1'b0;
      bus.e_addr_i     = 12'($urandom);

      notifyCyc = -1;
      t = 0;
      while (!bus.f_execDone_o && t < 20) begin
         @(negedge clock);
         t++;
      end
      if (bus.f_execDone_o) notifyCyc = cyc;
      checkVal("execDoneLat", 32'(notifyCyc - execCyc), 32'd6);
      checkVal("rspSize",     bus.f_rspSize_o, m);
      checkVal("sizeErrRsp",  32'(bus.sizeErr_o), 32'(cmdErr | rspErr));

      nWr = 0; bad = 0; firstCyc = -1; rspDoneCyc = -1; lastAddr = -1;
      t = 0;
      while (t < int'(m) + 20) begin
         @(negedge clock);
         t++;
         if (!bus.f_rspWren_n_o) begin
            if (nWr == 0) firstCyc = cyc;
            if (bus.f_rspAddr_o !== 12'(nWr) || bus.f_rspByte_o !== rspMem[12'(nWr)] ||
                cyc != firstCyc + nWr) bad++;
            lastAddr = int'(bus.f_rspAddr_o);
            nWr++;
            if (resetInRsp && nWr == 3) begin
               reset = 1'b1;
               #1;
               checkIdle("rstInRsp");
               @(negedge clock);
               reset = 1'b0;
               return;
            end
         end
         if (bus.f_rspDone_o) begin
            rspDoneCyc = cyc;
            break;
         end
      end
      checkVal("rspCount",    32'(nWr), m);
      checkVal("rspStart",    32'(firstCyc - notifyCyc), 32'd3);
      checkVal("rspBadBeats", 32'(bad), 32'd0);
      checkVal("rspLastAddr", 32'(lastAddr), m - 32'd1);
      checkVal("rspDoneAt",   32'(rspDoneCyc - firstCyc), m);
      @(negedge clock);
      checkIdle("postTxn");
   endtask

   task automatic abortTest();
      int t, dones, readies;
      txnId++;
      for (int i = 0; i < 20; i++) fifoMem[12'(i)] = 8'($urandom);
      @(negedge clock);
      bus.f_cmdSize_i = 32'd20;
      bus.f_cmdSend_i = 1'b1;
      @(negedge clock);
      bus.f_cmdSend_i = 1'b0;
      t = 0;
      while (bus.f_cmdAddr_o != 12'd5 && t < 20) begin
         @(negedge clock);
         t++;
      end
      checkVal("abortReachK5", 32'(bus.f_cmdAddr_o), 32'd5);
      bus.f_abort_i = 1'b1;
      @(negedge clock);
      bus.f_abort_i = 1'b0;
      checkIdle("abortIdle");
      dones = 0; readies = 0;
      repeat (30) begin
         if (bus.f_cmdDone_o)  dones++;
         if (bus.e_cmdReady_o) readies++;
         @(negedge clock);
      end
      checkVal("abortNoDone",  32'(dones),   32'd0);
      checkVal("abortNoReady", 32'(readies), 32'd0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: sim time got %0t limit reached before summary", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.f_abort_i    = 1'b0;
      bus.f_cmdSend_i  = 1'b0;
      bus.f_cmdSize_i  = '0;
      bus.e_addr_i     = '0;
      bus.e_wrData_i   = '0;
      bus.e_wren_n_i   = 1'b1;
      bus.e_execDone_i = 1'b0;
      repeat (3) @(negedge clock);
      checkIdle("reset");
      reset = 1'b0;
      repeat (2) @(negedge clock);

      runTxn(32'd12, 32'h0000_000A, 1'b1, 1'b0);
      runTxn(32'd4,  32'h0000_2000, 1'b0, 1'b0);
      abortTest();
      runTxn(32'd20, 32'd14, 1'b0, 1'b0);
      runTxn(32'd16, 32'd20, 1'b0, 1'b1);
      runTxn(32'd11, 32'd0,  1'b0, 1'b0);
      for (int r = 0; r < 5; r++)
         runTxn(32'($urandom_range(0, 80)), 32'($urandom_range(0, 80)), 1'b0, 1'b0);
      runTxn(32'd4096, 32'd4096, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
